loong_round_ctrl: RTL
=====================

LOONG_ROUND_CTRL -- requirements
Module: loong_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 16, number of full rounds (1..31).
REQ-002 Parameter MIX_TIMEOUT, default 8, maximum cycles spent waiting for mix_ack.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  pulse that begins encryption of pt_in under key_in.
REQ-006 pt_in  input  64  plaintext state; nibble [r][c] occupies bits [4*(4r+c)+:4].
REQ-007 key_in  input  64  cipher key, same nibble layout.
REQ-008 mix_req  output  1  one-cycle request to the shared mix engine.
REQ-009 mix_data  output  64  state handed to the mix engine; held stable from mix_req until mix_ack.
REQ-010 mix_ack  input  1  one-cycle pulse from the mix engine; mix_result is valid in that cycle.
REQ-011 mix_result  input  64  mix engine output.
REQ-012 busy  output  1  high from the cycle after an accepted start until done or err.
REQ-013 done  output  1  one-cycle pulse; ct_out is valid from this cycle.
REQ-014 ct_out  output  64  ciphertext; held until the next accepted start.
REQ-015 err  output  1  sticky timeout flag; cleared only by reset or an accepted start.

Function
REQ-016 FSM states: IDLE, ADDKEY, SUB, ROW_REQ, ROW_WAIT, COL_REQ, COL_WAIT, FINAL, DONE, ERR.
REQ-017 IDLE: start=1 latches pt_in into the state register and key_in into the key register, clears the round counter and err, and goes to ADDKEY; start in any other state is ignored.
REQ-018 ADDKEY (1 cycle): state ^= rk(round), where rk(n) = key rotated left by 4*n bits, XOR {59'b0, n[4:0]}; goes to SUB.
REQ-019 SUB (1 cycle): each of the 16 nibbles is replaced through the package S-box table; goes to ROW_REQ.
REQ-020 ROW_REQ (1 cycle): drives mix_req=1 and mix_data=state; goes to ROW_WAIT.
REQ-021 ROW_WAIT: on mix_ack, state <= mix_result and the FSM goes to COL_REQ.
REQ-022 COL_REQ/COL_WAIT: same as the row pass, with mix_data = transpose(state) and state <= transpose(mix_result); the column pass reuses the single row-mix engine.
REQ-023 After COL_WAIT the round counter increments; the FSM goes to ADDKEY if the counter is below NUM_ROUNDS, otherwise to FINAL.
REQ-024 FINAL (1 cycle): state ^= rk(NUM_ROUNDS) and ct_out <= the result; goes to DONE.
REQ-025 DONE (1 cycle): done=1; goes to IDLE.
REQ-026 Latency with ack delay d (ack arrives d cycles after the req cycle): start-to-done = NUM_ROUNDS*(4+2d)+2 cycles.
REQ-027 Each WAIT state counts cycles; when the count reaches MIX_TIMEOUT without an ack, the FSM enters ERR, sets err=1 and busy=0, and leaves state unchanged.
REQ-028 ERR goes to IDLE on the next cycle; err stays high.
REQ-029 mix_ack outside ROW_WAIT/COL_WAIT is ignored and changes no state.
REQ-030 mix_ack arriving in the same cycle as the timeout expiry counts as an ack, not a timeout.
REQ-031 mix_req is never asserted again while a previous request is outstanding.

Reset
REQ-032 Reset forces: FSM=IDLE, round counter=0, timeout counter=0, state/key registers=0, ct_out=0, mix_req=0, mix_data=0, busy=0, done=0, err=0.
REQ-033 Reset asserted mid-operation aborts the operation immediately; no done pulse follows.

Structure
REQ-034 Package loong_pkg holds the 16-entry S-box table, the state-enum type, the nibble index helper and a transpose function.
REQ-035 The mix engine is not instantiated inside this block; the integration wrapper connects it.
REQ-036 Sub-module loong_sbox4 (purely combinational, 4-bit in/out) is instantiated 16 times.

Verification
REQ-037 NUM_ROUNDS=1, identity mix stub, d=1, pt=0, key=0 -> done exactly 8 cycles after start; ct_out = S-box(0) in every nibble XOR rk(1).
REQ-038 Golden-model test: default parameters, GF(16) mix stub with d=3, 100 random pt/key pairs -> ct_out matches the model; 162 cycles per operation.
REQ-039 Stub never sends an ack -> err=1 after MIX_TIMEOUT wait cycles in the first ROW_WAIT; busy drops; no done pulse.
REQ-040 Reset deasserted during COL_WAIT of round 5 -> all outputs return to reset values; a subsequent start completes normally.
REQ-041 start pulsed while busy, plus a spurious mix_ack in SUB -> both ignored; ct_out matches the model.
REQ-042 Ack on exactly the timeout cycle -> err stays 0 and the operation completes.

Source files
------------

// File: rtl/loong_pkg.sv
// Shared definitions for the loong round controller: S-box, FSM encoding,
// nibble addressing and the state helpers used by the round datapath.
package loong_pkg;

  // 16-entry S-box; entry i sits in bits [4*i +: 4]
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  typedef enum logic [3:0] {
    LS_IDLE     = 4'd0,
    LS_ADDKEY   = 4'd1,
    LS_SUB      = 4'd2,
    LS_ROW_REQ  = 4'd3,
    LS_ROW_WAIT = 4'd4,
    LS_COL_REQ  = 4'd5,
    LS_COL_WAIT = 4'd6,
    LS_FINAL    = 4'd7,
    LS_DONE     = 4'd8,
    LS_ERR      = 4'd9
  } loong_state_e;

  // Bit offset of nibble [r][c] inside a 64-bit state word.
  function automatic int nib_idx(input int r, input int c);
    return 4 * (4 * r + c);
  endfunction

  function automatic logic [63:0] transpose(input logic [63:0] s);
    logic [63:0] t;
    t = 64'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[nib_idx(r, c) +: 4] = s[nib_idx(c, r) +: 4];
      end
    end
    return t;
  endfunction

  // Round key: key rotated left by whole nibbles, round number folded into the low bits.
  function automatic logic [63:0] round_key(input logic [63:0] key, input logic [4:0] n);
    logic [127:0] dbl;
    dbl = {key, key} << {n[3:0], 2'b00};
    return dbl[127:64] ^ {59'd0, n};
  endfunction

endpackage

// File: rtl/loong_sbox4.sv
// Single 4-bit S-box lane, purely combinational.
module loong_sbox4
  import loong_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // table lookup for one nibble
  always_comb begin
    dout = SBOX_TABLE[{din, 2'b00} +: 4];
  end

endmodule

// File: rtl/loong_round_ctrl.sv
// Round controller for the loong 64-bit cipher. Row and column diffusion both go
// through one external mix engine over a req/ack handshake with a wait timeout.
module loong_round_ctrl
  import loong_pkg::*;
#(
  parameter int NUM_ROUNDS  = 16,
  parameter int MIX_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] pt_in,
  input  logic [63:0] key_in,
  output logic        mix_req,
  output logic [63:0] mix_data,
  input  logic        mix_ack,
  input  logic [63:0] mix_result,
  output logic        busy,
  output logic        done,
  output logic [63:0] ct_out,
  output logic        err
);

  localparam logic [3:0] ST_IDLE     = LS_IDLE;
  localparam logic [3:0] ST_ADDKEY   = LS_ADDKEY;
  localparam logic [3:0] ST_SUB      = LS_SUB;
  localparam logic [3:0] ST_ROW_REQ  = LS_ROW_REQ;
  localparam logic [3:0] ST_ROW_WAIT = LS_ROW_WAIT;
  localparam logic [3:0] ST_COL_REQ  = LS_COL_REQ;
  localparam logic [3:0] ST_COL_WAIT = LS_COL_WAIT;
  localparam logic [3:0] ST_FINAL    = LS_FINAL;
  localparam logic [3:0] ST_DONE     = LS_DONE;
  localparam logic [3:0] ST_ERR      = LS_ERR;

  localparam int TW = $clog2(MIX_TIMEOUT) + 1;

  logic [3:0]    fsm_r;
  logic [63:0]   st_r;
  logic [63:0]   key_r;
  logic [4:0]    round_r;
  logic [TW-1:0] tmo_r;
  logic          mix_req_r;
  logic [63:0]   mix_data_r;
  logic          busy_r;
  logic          done_r;
  logic [63:0]   ct_r;
  logic          err_r;

  logic [63:0]   sub_s;
  logic [63:0]   rk_s;
  logic          tmo_hit_s;
  logic          last_round_s;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    loong_sbox4 u_sbox (
      .din  (st_r[4*i +: 4]),
      .dout (sub_s[4*i +: 4])
    );
  end

  // round_r equals NUM_ROUNDS in FINAL, so one key generator serves ADDKEY and FINAL
  assign rk_s         = round_key(key_r, round_r);
  assign tmo_hit_s    = (tmo_r == TW'(MIX_TIMEOUT - 1));
  assign last_round_s = ((round_r + 5'd1) >= 5'(NUM_ROUNDS));

  assign mix_req  = mix_req_r;
  assign mix_data = mix_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign ct_out   = ct_r;
  assign err      = err_r;

  // round sequencing, datapath and registered handshake outputs
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      fsm_r      <= ST_IDLE;
      st_r       <= 64'd0;
      key_r      <= 64'd0;
      round_r    <= 5'd0;
      tmo_r      <= '0;
      mix_req_r  <= 1'b0;
      mix_data_r <= 64'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ct_r       <= 64'd0;
      err_r      <= 1'b0;
    end else begin
      mix_req_r <= 1'b0;
      done_r    <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (start) begin
            st_r    <= pt_in;
            key_r   <= key_in;
            round_r <= 5'd0;
            tmo_r   <= '0;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            fsm_r   <= ST_ADDKEY;
          end else begin
            fsm_r <= ST_IDLE;
          end
        end
        ST_ADDKEY: begin
          st_r  <= st_r ^ rk_s;
          fsm_r <= ST_SUB;
        end
        ST_SUB: begin
          // request is launched together with the substituted state so data and req align
          st_r       <= sub_s;
          mix_data_r <= sub_s;
          mix_req_r  <= 1'b1;
          fsm_r      <= ST_ROW_REQ;
        end
        ST_ROW_REQ: begin
          tmo_r <= '0;
          fsm_r <= ST_ROW_WAIT;
        end
        ST_ROW_WAIT: begin
          if (mix_ack) begin
            st_r       <= mix_result;
            mix_data_r <= transpose(mix_result);
            mix_req_r  <= 1'b1;
            fsm_r      <= ST_COL_REQ;
          end else if (tmo_hit_s) begin
            err_r  <= 1'b1;
            busy_r <= 1'b0;
            fsm_r  <= ST_ERR;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_COL_REQ: begin
          tmo_r <= '0;
          fsm_r <= ST_COL_WAIT;
        end
        ST_COL_WAIT: begin
          if (mix_ack) begin
            st_r    <= transpose(mix_result);
            round_r <= round_r + 5'd1;
            fsm_r   <= last_round_s ? ST_FINAL : ST_ADDKEY;
          end else if (tmo_hit_s) begin
            err_r  <= 1'b1;
            busy_r <= 1'b0;
            fsm_r  <= ST_ERR;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_FINAL: begin
          st_r   <= st_r ^ rk_s;
          ct_r   <= st_r ^ rk_s;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          fsm_r  <= ST_DONE;
        end
        ST_DONE: begin
          fsm_r <= ST_IDLE;
        end
        ST_ERR: begin
          fsm_r <= ST_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          fsm_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
